// File: rtl/tdm2p_if.sv
// rtl/tdm2p_if.sv - TDM receive link and parallel frame output bundle for tdm2p
interface tdm2p_if #(
  parameter int FRAME_BITS = 256
);
  logic                  enable;
  logic                  sclk;
  logic                  fs;
  logic                  tdmin;
  logic                  valid;
  logic [FRAME_BITS-1:0] pdata;
  logic                  locked;
  logic                  bitSlipIncr;
  logic                  fsMissIncr;

  modport master (
    output enable, sclk, fs, tdmin,
    input  valid, pdata, locked, bitSlipIncr, fsMissIncr
  );

  modport slave (
    input  enable, sclk, fs, tdmin,
    output valid, pdata, locked, bitSlipIncr, fsMissIncr
  );
endinterface

// File: rtl/tdm2p.sv
// rtl/tdm2p.sv - oversampled TDM deserializer, one FS-aligned frame per valid strobe
module tdm2p #(
  parameter int FRAME_BITS = 256,
  parameter int SYNC_FLOPS = 2
) (
  input  logic  i_clk,
  input  logic  i_rst,
  tdm2p_if.slave bus
);
  localparam int CW = $clog2(FRAME_BITS);
  localparam logic [CW-1:0] LAST = CW'(FRAME_BITS - 1);

  typedef enum logic {
    HUNT = 1'b0,
    RECV = 1'b1
  } state_t;

  logic [SYNC_FLOPS-1:0] r_sclk_sync;
  logic [SYNC_FLOPS-1:0] r_fs_sync;
  logic [SYNC_FLOPS-1:0] r_din_sync;
  logic                  r_sclk_d;

  state_t                r_state;
  state_t                w_state_nx;
  logic [CW-1:0]         r_cnt;
  logic [CW-1:0]         w_cnt_nx;
  logic [FRAME_BITS-1:0] r_shreg;
  logic [FRAME_BITS-1:0] r_pdata;
  logic                  r_valid;
  logic                  r_slip;
  logic                  r_miss;

  logic                  w_sclk_s;
  logic                  w_fs_s;
  logic                  w_din_s;
  logic                  w_sample;
  logic                  w_clear;
  logic                  w_wr;
  logic [CW-1:0]         w_wr_idx;
  logic                  w_valid_nx;
  logic                  w_slip_nx;
  logic                  w_miss_nx;

  // Synchronizers keep running while disabled so edge detection is sane on re-enable
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sclk_sync <= '0;
      r_fs_sync   <= '0;
      r_din_sync  <= '0;
      r_sclk_d    <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_FLOPS-2:0], bus.sclk};
      r_fs_sync   <= {r_fs_sync[SYNC_FLOPS-2:0], bus.fs};
      r_din_sync  <= {r_din_sync[SYNC_FLOPS-2:0], bus.tdmin};
      r_sclk_d    <= w_sclk_s;
    end
  end

  assign w_sclk_s = r_sclk_sync[SYNC_FLOPS-1];
  assign w_fs_s   = r_fs_sync[SYNC_FLOPS-1];
  assign w_din_s  = r_din_sync[SYNC_FLOPS-1];
  assign w_sample = r_sclk_d & ~w_sclk_s;
  assign w_clear  = i_rst | ~bus.enable;
  assign w_wr_idx = w_fs_s ? '0 : r_cnt;

  always_ff @(posedge i_clk) begin
    if (w_clear) begin
      r_state <= HUNT;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_wr       = 1'b0;
    w_valid_nx = 1'b0;
    w_slip_nx  = 1'b0;
    w_miss_nx  = 1'b0;
    if (w_sample) begin
      unique case (r_state)
        HUNT: begin
          if (w_fs_s) begin
            w_state_nx = RECV;
            w_cnt_nx   = CW'(1);
            w_wr       = 1'b1;
          end
        end
        RECV: begin
          if (w_fs_s) begin
            // FS anywhere but bit 0 resyncs on this bit and drops the partial frame
            w_slip_nx = (r_cnt != '0);
            w_cnt_nx  = CW'(1);
            w_wr      = 1'b1;
          end else if (r_cnt == '0) begin
            w_miss_nx  = 1'b1;
            w_state_nx = HUNT;
          end else begin
            w_wr       = 1'b1;
            w_valid_nx = (r_cnt == LAST);
            w_cnt_nx   = (r_cnt == LAST) ? '0 : r_cnt + CW'(1);
          end
        end
        default: w_state_nx = HUNT;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_clear) begin
      r_cnt   <= '0;
      r_shreg <= '0;
      r_pdata <= '0;
      r_valid <= 1'b0;
      r_slip  <= 1'b0;
      r_miss  <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nx;
      r_valid <= w_valid_nx;
      r_slip  <= w_slip_nx;
      r_miss  <= w_miss_nx;
      if (w_wr) begin
        r_shreg[w_wr_idx] <= w_din_s;
      end
      if (w_valid_nx) begin
        r_pdata <= {w_din_s, r_shreg[FRAME_BITS-2:0]};
      end
    end
  end

  assign bus.valid       = r_valid;
  assign bus.pdata       = r_pdata;
  assign bus.locked      = (r_state == RECV);
  assign bus.bitSlipIncr = r_slip;
  assign bus.fsMissIncr  = r_miss;
endmodule

// File: tb/tb_tdm2p.sv
// tb/tb_tdm2p.sv - self-checking bench for tdm2p against a frame-level reference model
module tb_tdm2p;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  tdm2p_if bus ();
  tdm2p dut (.i_clk(clk), .i_rst(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [255:0] data;
    int           period;
    int           phase;
    logic [255:0] exp;
  } vec_t;

  // Reference model state: bits of the frame in progress, completed frames, error tallies
  bit            m_locked;
  bit            m_q[$];
  logic [255:0]  exp_q[$];
  int            exp_slip, exp_miss;

  logic [255:0]  obs_q[$];
  logic [255:0]  obs_hist[$];
  int            obs_slip, obs_miss;
  int            last_fall;
  bit            prev_valid, prev_slip, prev_miss;

  task automatic check_int(input string name, input int act, input int req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic check_vec(input string name, input logic [255:0] act, input logic [255:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic m_reset();
    m_locked = 0;
    m_q.delete();
  endtask

  task automatic m_bit(input bit fs, input bit d);
    logic [255:0] f;
    if (!m_locked) begin
      if (fs) begin
        m_q = {d};
        m_locked = 1;
      end
    end else if (fs) begin
      if (m_q.size() != 0) exp_slip++;
      m_q = {d};
    end else if (m_q.size() == 0) begin
      exp_miss++;
      m_locked = 0;
    end else begin
      m_q.push_back(d);
      if (m_q.size() == 256) begin
        for (int i = 0; i < 256; i++) f[i] = m_q[i];
        exp_q.push_back(f);
        m_q.delete();
      end
    end
  endtask

  always @(negedge clk) begin
    if (bus.valid) begin
      obs_q.push_back(bus.pdata);
      obs_hist.push_back(bus.pdata);
      check_int("valid_latency", cyc - last_fall, 3);
      check_int("valid_single", int'(prev_valid), 0);
    end
    if (bus.bitSlipIncr) begin
      obs_slip++;
      check_int("slip_latency", cyc - last_fall, 3);
      check_int("slip_single", int'(prev_slip), 0);
    end
    if (bus.fsMissIncr) begin
      obs_miss++;
      check_int("miss_latency", cyc - last_fall, 3);
      check_int("miss_single", int'(prev_miss), 0);
    end
    prev_valid = bus.valid;
    prev_slip  = bus.bitSlipIncr;
    prev_miss  = bus.fsMissIncr;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input bit fs, input bit d, input int p);
    @(negedge clk);
    bus.fs = fs;
    bus.tdmin = d;
    bus.sclk = 1'b1;
    repeat (p / 2) @(negedge clk);
    bus.sclk = 1'b0;
    last_fall = cyc;
    m_bit(fs, d);
    repeat (p - p / 2 - 1) @(negedge clk);
  endtask

  task automatic send_bits(input logic [255:0] data, input int from, input int to,
                           input int p, input bit with_fs);
    for (int k = from; k < to; k++) send_bit(with_fs && (k == 0), data[k], p);
  endtask

  task automatic send_frame(input logic [255:0] data, input int p);
    send_bits(data, 0, 256, p, 1'b1);
  endtask

  task automatic flush(input string tag);
    int n;
    idle(6);
    check_int({tag, "_frames"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check_vec({tag, "_pdata"}, obs_q[i], exp_q[i]);
    obs_q.delete();
    exp_q.delete();
    check_int({tag, "_slips"}, obs_slip, exp_slip);
    check_int({tag, "_misses"}, obs_miss, exp_miss);
    check_int({tag, "_locked"}, int'(bus.locked), int'(m_locked));
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int j = 0; j < 8; j++) r[j*32 +: 32] = $urandom;
    return r;
  endfunction

  initial begin
    vec_t         tbl[11];
    logic [255:0] w;
    logic [255:0] d;
    int           base, s0, m0, p, n;
    bit           seen;

    bus.enable = 1'b1;
    bus.sclk   = 1'b0;
    bus.fs     = 1'b0;
    bus.tdmin  = 1'b0;
    m_reset();
    exp_slip = 0; exp_miss = 0; obs_slip = 0; obs_miss = 0;
    last_fall = -100;

    tbl[0].data = {4{64'h0123456789abcdef}}; tbl[0].period = 4; tbl[0].phase = 0;
    tbl[1].data = '1;                        tbl[1].period = 4; tbl[1].phase = 0;
    w = 256'd1;
    tbl[2].data = w << 200;                  tbl[2].period = 4; tbl[2].phase = 0;
    for (int i = 3; i < 11; i++) begin
      tbl[i].data   = rand256();
      tbl[i].period = (i < 7) ? 4 : 17;
      tbl[i].phase  = (i - 3) % 4;
    end
    for (int i = 0; i < 11; i++) tbl[i].exp = tbl[i].data;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_int("rst_valid", int'(bus.valid), 0);
    check_vec("rst_pdata", bus.pdata, '0);
    check_int("rst_locked", int'(bus.locked), 0);
    check_int("rst_slip", int'(bus.bitSlipIncr), 0);
    check_int("rst_miss", int'(bus.fsMissIncr), 0);

    // Back-to-back frames, then sclk rate and phase sweep
    base = obs_hist.size();
    for (int i = 0; i < 3; i++) send_frame(tbl[i].data, tbl[i].period);
    flush("t1");
    for (int i = 3; i < 11; i++) begin
      idle(tbl[i].phase);
      send_frame(tbl[i].data, tbl[i].period);
      flush("t2");
    end
    for (int i = 0; i < 11; i++)
      if (base + i < obs_hist.size()) check_vec("table_pdata", obs_hist[base + i], tbl[i].exp);
      else check_int("table_count", obs_hist.size() - base, 11);

    // FS slip at bit 100
    s0 = obs_slip;
    send_bits(rand256(), 0, 100, 4, 1'b1);
    send_frame(rand256(), 4);
    flush("t3");
    check_int("t3_one_slip", obs_slip - s0, 1);

    // Missing FS at the boundary after one frame
    m0 = obs_miss;
    send_frame(rand256(), 4);
    send_bits(rand256(), 0, 256, 4, 1'b0);
    idle(4);
    check_int("t4_unlocked", int'(bus.locked), 0);
    check_int("t4_one_miss", obs_miss - m0, 1);
    send_frame(rand256(), 4);
    flush("t4");

    // enable dropped for 5 clk at bit 130
    d = rand256();
    send_bits(d, 0, 130, 4, 1'b1);
    idle(4);
    bus.enable = 1'b0;
    m_reset();
    idle(5);
    check_vec("t5_pdata_zero", bus.pdata, '0);
    check_int("t5_unlocked", int'(bus.locked), 0);
    bus.enable = 1'b1;
    send_bits(d, 130, 256, 4, 1'b0);
    send_frame(rand256(), 4);
    flush("t5");

    // rst during the valid cycle
    send_frame(rand256(), 4);
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = bus.valid;
    end
    check_int("t6_valid_seen", int'(seen), 1);
    rst = 1'b1;
    m_reset();
    @(negedge clk);
    rst = 1'b0;
    check_int("t6_valid_cleared", int'(bus.valid), 0);
    check_vec("t6_pdata_cleared", bus.pdata, '0);
    check_int("t6_unlocked", int'(bus.locked), 0);
    flush("t6a");

    // sclk stalled 1000 clk mid-frame
    d = rand256();
    send_bits(d, 0, 60, 4, 1'b1);
    idle(1000);
    send_bits(d, 60, 256, 4, 1'b0);
    flush("t6b");

    // Randomised periods with optional slipped partial frames
    for (int r = 0; r < 6; r++) begin
      p = $urandom_range(4, 9);
      if ($urandom_range(0, 1) == 1) begin
        n = $urandom_range(1, 255);
        send_bits(rand256(), 0, n, p, 1'b1);
      end
      idle($urandom_range(0, 5));
      send_frame(rand256(), p);
      flush("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL timeout: got cycle %0d expected completion", cyc);
    $fatal(1);
  end
endmodule
